hms_timekeeper: RTL and testbench

//  Parametrised BCD time-of-day core: divides Clk to a 1 s tick and keeps hh:mm:ss.

---
 rtl/hms_timekeeper_pkg.sv | 64 ++++++
 rtl/hms_timekeeper_bcd_mod_counter.sv | 41 ++++
 rtl/hms_timekeeper.sv | 161 ++++++++++++++++
 tb/tb_hms_timekeeper.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hms_timekeeper_pkg.sv
// Shared definitions for the hh:mm:ss timekeeper: field/state encodings, BCD limits
// and the BCD step and 12-hour display helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2
  } field_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_e;

  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MAX_HR = 8'h23;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == 4'h9) begin
      r = {v[7:4] + 4'h1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'h1};
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = max_v;
    end else if (v[3:0] == 4'h0) begin
      r = {v[7:4] - 4'h1, 4'h9};
    end else begin
      r = {v[7:4], v[3:0] - 4'h1};
    end
    return r;
  endfunction

  // 24-h BCD hour to the 12-h display hour; 00 shows as 12.
  function automatic logic [7:0] hour_to_12h(input logic [7:0] hour_bcd);
    logic [7:0] r;
    case (hour_bcd)
      8'h00:   r = 8'h12;
      8'h13:   r = 8'h01;
      8'h14:   r = 8'h02;
      8'h15:   r = 8'h03;
      8'h16:   r = 8'h04;
      8'h17:   r = 8'h05;
      8'h18:   r = 8'h06;
      8'h19:   r = 8'h07;
      8'h20:   r = 8'h08;
      8'h21:   r = 8'h09;
      8'h22:   r = 8'h10;
      8'h23:   r = 8'h11;
      default: r = hour_bcd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hms_timekeeper_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX; carry_en counts with carry-out, inc/dec edit without carry.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX     = 8'h59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_en,
  output logic       carry_out,
  output logic [7:0] value,
  output logic [7:0] value_next
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (carry_en || (inc && !dec)) begin
      value_d = bcd_inc(value_q, MAX);
    end else if (dec && !inc) begin
      value_d = bcd_dec(value_q, MAX);
    end else begin
      value_d = value_q;
    end
  end

  // The next value is exported so the parent can register its display copy in step.
  assign value_next = reset ? RST_VAL : value_d;
  assign carry_out  = carry_en && (value_q == MAX);
  assign value      = value_q;

  always_ff @(posedge clk) begin
    value_q <= value_next;
  end

endmodule

// File: rtl/hms_timekeeper.sv
// BCD time-of-day core with key-driven set mode and optional 12-hour display.
// Alarm compare is built only when the macro ALARM_EN is defined.
module hms_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter bit          TWELVE_HOUR = 1'b0,
  parameter logic [23:0] PRESET_HMS  = 24'h000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Set_toggle,
  input  logic        Field_next,
  input  logic        Inc,
  input  logic        Dec,
  input  logic        Alarm_wr,
  input  logic [23:0] Alarm_time,
  output logic [23:0] Time_bcd,
  output logic        Pm,
  output logic        Setting,
  output logic [1:0]  Field_sel,
  output logic        Sec_tick,
  output logic        Day_tick,
  output logic        Alarm_hit
);

  localparam int unsigned PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ_HZ - 1);

  state_e        state_q, state_d;
  field_e        field_q, field_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_s, set_inc_s, set_dec_s;
  logic          ss_carry_s, mm_carry_s, hh_carry_s;
  logic [7:0]    ss_n, mm_n, hh_n, disp_hr_s;
  logic [7:0]    ss_v, mm_v, hh_v;
  logic          hit_s;
  logic [23:0]   time_q;
  logic          pm_q, sec_q, day_q, hit_q;

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    presc_d   = {PW{1'b0}};
    tick_s    = 1'b0;
    set_inc_s = 1'b0;
    set_dec_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (Set_toggle) begin
          state_d = ST_SET;
        end else if (presc_q == PRESC_LAST) begin
          tick_s = 1'b1;
        end else begin
          presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      ST_SET: begin
        if (Set_toggle) begin
          state_d = ST_RUN;
        end else if (Field_next) begin
          case (field_q)
            FLD_SEC:  field_d = FLD_MIN;
            FLD_MIN:  field_d = FLD_HOUR;
            default:  field_d = FLD_SEC;
          endcase
        end else if (Inc ^ Dec) begin
          set_inc_s = Inc;
          set_dec_s = Dec;
        end else begin
          field_d = field_q;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      field_q <= FLD_SEC;
      presc_q <= {PW{1'b0}};
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      presc_q <= presc_d;
    end
  end

  bcd_mod_counter #(.MAX(BCD_MAX_MS), .RST_VAL(PRESET_HMS[7:0])) u_ss (
    .clk(Clk), .reset(Reset),
    .inc(set_inc_s && (field_q == FLD_SEC)), .dec(set_dec_s && (field_q == FLD_SEC)),
    .carry_en(tick_s), .carry_out(ss_carry_s), .value(ss_v), .value_next(ss_n)
  );

  bcd_mod_counter #(.MAX(BCD_MAX_MS), .RST_VAL(PRESET_HMS[15:8])) u_mm (
    .clk(Clk), .reset(Reset),
    .inc(set_inc_s && (field_q == FLD_MIN)), .dec(set_dec_s && (field_q == FLD_MIN)),
    .carry_en(ss_carry_s), .carry_out(mm_carry_s), .value(mm_v), .value_next(mm_n)
  );

  bcd_mod_counter #(.MAX(BCD_MAX_HR), .RST_VAL(PRESET_HMS[23:16])) u_hh (
    .clk(Clk), .reset(Reset),
    .inc(set_inc_s && (field_q == FLD_HOUR)), .dec(set_dec_s && (field_q == FLD_HOUR)),
    .carry_en(mm_carry_s), .carry_out(hh_carry_s), .value(hh_v), .value_next(hh_n)
  );

  always_comb begin
    if (TWELVE_HOUR) begin
      disp_hr_s = hour_to_12h(hh_n);
    end else begin
      disp_hr_s = hh_n;
    end
  end

`ifdef ALARM_EN
  logic [15:0] alarm_q;
  logic        unused_s;

  // The compare below sees the pre-write alarm when Alarm_wr coincides with a match.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      alarm_q <= 16'h0000;
    end else if (Alarm_wr) begin
      alarm_q <= Alarm_time[23:8];
    end else begin
      alarm_q <= alarm_q;
    end
  end

  assign hit_s    = tick_s && (ss_n == 8'h00) && ({hh_n, mm_n} == alarm_q);
  assign unused_s = ^{Alarm_time[7:0], ss_v, mm_v, hh_v};
`else
  logic unused_s;
  assign hit_s    = 1'b0;
  assign unused_s = ^{Alarm_wr, Alarm_time, ss_v, mm_v, hh_v};
`endif

  always_ff @(posedge Clk) begin
    time_q <= {disp_hr_s, mm_n, ss_n};
    pm_q   <= TWELVE_HOUR && (hh_n >= 8'h12);
    if (Reset) begin
      sec_q <= 1'b0;
      day_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      sec_q <= tick_s;
      day_q <= hh_carry_s;
      hit_q <= hit_s;
    end
  end

  assign Time_bcd  = time_q;
  assign Pm        = pm_q;
  assign Setting   = (state_q == ST_SET);
  assign Field_sel = field_q;
  assign Sec_tick  = sec_q;
  assign Day_tick  = day_q;
  assign Alarm_hit = hit_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Self-checking bench: a 24-h and a 12-h instance share stimulus and are compared every
// cycle against a seconds-of-day model; directed cases pin the model with literal values.
module tb_hms_timekeeper;

  localparam int N = 4;
  localparam logic [23:0] P0 = 24'h235958;
  localparam logic [23:0] P1 = 24'h000000;

  logic        clk = 1'b0;
  logic        reset, tog, fnx, inc, dec, awr;
  logic [23:0] atime;
  logic [23:0] time_o [2];
  logic        pm_o [2], set_o [2], sec_o [2], day_o [2], hit_o [2];
  logic [1:0]  fld_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  int tod [2];
  bit m_set, m_valid, m_sec;
  int m_field, m_presc, m_alarm;
  bit m_day [2];
  bit m_hit [2];

  always #5 clk = ~clk;

  hms_timekeeper #(.CLK_FREQ_HZ(N), .TWELVE_HOUR(1'b0), .PRESET_HMS(P0)) dut0 (
    .Clk(clk), .Reset(reset), .Set_toggle(tog), .Field_next(fnx), .Inc(inc), .Dec(dec),
    .Alarm_wr(awr), .Alarm_time(atime), .Time_bcd(time_o[0]), .Pm(pm_o[0]),
    .Setting(set_o[0]), .Field_sel(fld_o[0]), .Sec_tick(sec_o[0]), .Day_tick(day_o[0]),
    .Alarm_hit(hit_o[0]));

  hms_timekeeper #(.CLK_FREQ_HZ(N), .TWELVE_HOUR(1'b1), .PRESET_HMS(P1)) dut1 (
    .Clk(clk), .Reset(reset), .Set_toggle(tog), .Field_next(fnx), .Inc(inc), .Dec(dec),
    .Alarm_wr(awr), .Alarm_time(atime), .Time_bcd(time_o[1]), .Pm(pm_o[1]),
    .Setting(set_o[1]), .Field_sel(fld_o[1]), .Sec_tick(sec_o[1]), .Day_tick(day_o[1]),
    .Alarm_hit(hit_o[1]));

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int hms_to_sec(input logic [23:0] p);
    return from_bcd(p[23:16]) * 3600 + from_bcd(p[15:8]) * 60 + from_bcd(p[7:0]);
  endfunction

  function automatic logic [23:0] exp_time(input int i);
    int h, dh;
    h  = tod[i] / 3600;
    dh = (i == 1) ? ((h % 12 == 0) ? 12 : h % 12) : h;
    return {to_bcd(dh), to_bcd((tod[i] / 60) % 60), to_bcd(tod[i] % 60)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int h, m, s, dl, old_alarm;
    m_sec = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_day[i] = 1'b0;
      m_hit[i] = 1'b0;
    end
    if (reset) begin
      tod[0] = hms_to_sec(P0);
      tod[1] = hms_to_sec(P1);
      m_set = 1'b0; m_field = 0; m_presc = 0; m_alarm = 0; m_valid = 1'b1;
    end else begin
      old_alarm = m_alarm;
`ifdef ALARM_EN
      if (awr) m_alarm = from_bcd(atime[23:16]) * 60 + from_bcd(atime[15:8]);
`endif
      if (!m_set) begin
        if (tog) begin
          m_set = 1'b1; m_presc = 0;
        end else if (m_presc == N - 1) begin
          m_presc = 0; m_sec = 1'b1;
          for (int i = 0; i < 2; i++) begin
            tod[i]   = (tod[i] + 1) % 86400;
            m_day[i] = (tod[i] == 0);
`ifdef ALARM_EN
            m_hit[i] = (tod[i] % 60 == 0) && (tod[i] / 60 == old_alarm);
`endif
          end
        end else begin
          m_presc++;
        end
      end else begin
        m_presc = 0;
        if (tog) m_set = 1'b0;
        else if (fnx) m_field = (m_field + 1) % 3;
        else if (inc != dec) begin
          dl = inc ? 1 : -1;
          for (int i = 0; i < 2; i++) begin
            h = tod[i] / 3600; m = (tod[i] / 60) % 60; s = tod[i] % 60;
            if (m_field == 0) s = (s + dl + 60) % 60;
            else if (m_field == 1) m = (m + dl + 60) % 60;
            else h = (h + dl + 24) % 24;
            tod[i] = h * 3600 + m * 60 + s;
          end
        end
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("time%0d", i), time_o[i], exp_time(i));
        chk($sformatf("pm%0d", i), pm_o[i], (i == 1) && (tod[i] / 3600 >= 12));
        chk($sformatf("setting%0d", i), set_o[i], m_set);
        chk($sformatf("field%0d", i), fld_o[i], m_field);
        chk($sformatf("sec_tick%0d", i), sec_o[i], m_sec);
        chk($sformatf("day_tick%0d", i), day_o[i], m_day[i]);
        chk($sformatf("alarm_hit%0d", i), hit_o[i], m_hit[i]);
      end
    end
  end

  task automatic step(input logic t, input logic f, input logic ii, input logic d,
                      input logic r, input logic aw, input logic [23:0] at);
    tog = t; fnx = f; inc = ii; dec = d; reset = r; awr = aw; atime = at;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
  endtask

  initial begin
    int days, cnt, r;
    logic [23:0] tv;
    m_valid = 1'b0;
    tog = 1'b0; fnx = 1'b0; inc = 1'b0; dec = 1'b0; awr = 1'b0; atime = 24'h000000;
    reset = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
    chk("rst_time24", time_o[0], 24'h235958);
    chk("rst_time12", time_o[1], 24'h120000);
    chk("rst_setting", set_o[0], 1'b0);
    chk("rst_field", fld_o[0], 2'd0);

    // Rollover from 23:59:58.
    days = 0;
    for (int c = 1; c <= 8; c++) begin
      idle();
      days += int'(day_o[0]);
      if (c == 4) begin
        chk("t1_235959", time_o[0], 24'h235959);
        chk("t1_sec_tick", sec_o[0], 1'b1);
      end
      if (c == 8) begin
        chk("t1_wrap", time_o[0], 24'h000000);
        chk("t1_day_aligned", day_o[0], 1'b1);
        chk("t1_12h", time_o[1], 24'h120002);
      end
    end
    chk("t1_day_count", days, 1);

    // Minute edit wraps without carrying into the hour.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    chk("t2_setting", set_o[0], 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    chk("t2_field_min", fld_o[0], 2'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    chk("t2_dec_min", time_o[0], 24'h005900);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    chk("t2_inc_wrap", time_o[0], 24'h000000);
    for (int c = 0; c < 6; c++) begin
      idle();
      chk("t2_no_sec_tick", sec_o[0], 1'b0);
    end

    // Hour edit, and Inc+Dec together ignored.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    chk("t3_field_hour", fld_o[0], 2'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    chk("t3_dec_hour", time_o[0], 24'h230000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000);
    chk("t3_inc_dec", time_o[0], 24'h230000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);

    // First tick after leaving SET.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    cnt = 0;
    while (cnt < 10) begin
      idle();
      cnt++;
      if (sec_o[0]) break;
    end
    chk("t4_tick_latency", cnt, 4);
    chk("t4_ss_plus1", time_o[0], 24'h000001);

    // 12-hour mapping on dut1 (internal hour currently 00).
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    tv = time_o[1];
    chk("t5_h00_disp", tv[23:16], 8'h12);
    chk("t5_h00_pm", pm_o[1], 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    tv = time_o[1];
    chk("t5_h12_disp", tv[23:16], 8'h12);
    chk("t5_h12_pm", pm_o[1], 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    tv = time_o[1];
    chk("t5_h13_disp", tv[23:16], 8'h01);
    chk("t5_h13_pm", pm_o[1], 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);

`ifdef ALARM_EN
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h073000);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
      repeat (30) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
      repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
      chk("t6_preset", time_o[0], 24'h072959);
      if (pass == 0) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
        repeat (4) idle();
        chk("t6_hit", hit_o[0], 1'b1);
        chk("t6_hit_time", time_o[0], 24'h073000);
        idle();
        chk("t6_hit_one_cycle", hit_o[0], 1'b0);
      end else begin
        cnt = 0;
        repeat (8) begin
          idle();
          cnt += int'(hit_o[0]);
        end
        chk("t6_set_no_hit", cnt, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
      end
    end
`endif

    // Randomized traffic checked by the per-cycle compare.
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 99));
      tv = {to_bcd(((tod[0] / 60 + 1) % 1440) / 60), to_bcd((tod[0] / 60 + 1) % 60), 8'h00};
      step(r < 3, (r >= 3) && (r < 10), (r >= 10) && (r < 25), (r >= 20) && (r < 35),
           $urandom_range(0, 399) == 0, $urandom_range(0, 19) == 0, tv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
